// File: rtl/mem_request_queue.sv
// mem_request_queue
//   Circular DRAM request queue sitting between the trace parser and the DRAM
//   command scheduler. Requests carry the CPU clock count at which they become
//   due; the queue keeps its own CPU clock count, jumps over idle time while
//   empty, ages every stored entry and issues strictly in FIFO order, either as
//   soon as the head is valid or only once the head has reached AGE_LIMIT.
//
// Ports
//   CPU_clock    clock
//   rst_n        synchronous, active-low reset
//   in_valid     parser request valid (held until in_ready)
//   in_time      request CPU clock count
//   in_op        request opcode (0=read, 1=write, 2=ifetch)
//   in_addr      request address
//   in_ready     request consumed this cycle (inserted or dropped)
//   out_valid    head entry eligible for issue
//   out_ready    scheduler accepts head
//   out_time     head request time (0 when empty)
//   out_op       head opcode (0 when empty)
//   out_addr     head address (0 when empty)
//   cpu_time     local CPU clock count
//   count        occupancy
//   full/empty   occupancy status
//   insert_flag  one-cycle pulse after an insert
//   exit_flag    one-cycle pulse after a pop
//   drop_flag    one-cycle pulse after a drop
//   drop_count   total drops, saturating at 2^32-1

module mem_request_queue #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 33,
  parameter int OP_W         = 2,
  parameter int TIME_W       = 64,
  parameter int AGE_LIMIT    = 100,
  parameter int ISSUE_MODE   = 0,
  parameter int DROP_ON_FULL = 1
) (
  input  logic                     CPU_clock,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [TIME_W-1:0]        in_time,
  input  logic [OP_W-1:0]          in_op,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TIME_W-1:0]        out_time,
  output logic [OP_W-1:0]          out_op,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [TIME_W-1:0]        cpu_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     insert_flag,
  output logic                     exit_flag,
  output logic                     drop_flag,
  output logic [31:0]              drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [TIME_W-1:0] time_mem [DEPTH];
  logic [OP_W-1:0]   op_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [AGE_W-1:0]  age      [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic due;
  logic push;
  logic drop;
  logic pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A late request (in_time < cpu_time) is simply due; only future requests wait.
  assign due = in_valid && (in_time <= cpu_time);

  // When full, readiness deliberately ignores out_ready so a same-cycle pop
  // never opens a slot for the pending request.
  assign in_ready = due && (!full || (DROP_ON_FULL != 0));
  assign push     = due && !full;
  assign drop     = due && full && (DROP_ON_FULL != 0);

  assign out_valid = !empty && ((ISSUE_MODE != 0) || (age[rd_ptr] == AGE_MAX));
  assign pop       = out_valid && out_ready;

  assign out_time = empty ? '0 : time_mem[rd_ptr];
  assign out_op   = empty ? '0 : op_mem[rd_ptr];
  assign out_addr = empty ? '0 : addr_mem[rd_ptr];

  // Control state: pointers, occupancy, local time, drop accounting and flags.
  always_ff @(posedge CPU_clock) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cpu_time    <= '0;
      drop_count  <= '0;
      insert_flag <= 1'b0;
      exit_flag   <= 1'b0;
      drop_flag   <= 1'b0;
    end else begin
      // Idle skip: with nothing queued there is no reason to count up to a future request.
      if (empty && in_valid && (in_time > cpu_time)) begin
        cpu_time <= in_time;
      end else begin
        cpu_time <= cpu_time + TIME_W'(1);
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (drop && (drop_count != 32'hFFFF_FFFF)) begin
        drop_count <= drop_count + 32'd1;
      end

      insert_flag <= push;
      exit_flag   <= pop;
      drop_flag   <= drop;
    end
  end

  // Per-entry validity and saturating age. The write slot is never valid when
  // pushing (push needs !full), so the fresh age of 0 cannot collide with aging.
  always_ff @(posedge CPU_clock) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        age[wr_ptr]   <= '0;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked separately above.
  always_ff @(posedge CPU_clock) begin
    if (push) begin
      time_mem[wr_ptr] <= in_time;
      op_mem[wr_ptr]   <= in_op;
      addr_mem[wr_ptr] <= in_addr;
    end
  end

endmodule

// File: tb/tb_mem_request_queue.sv
// tb_mem_request_queue
//   Self-checking bench for mem_request_queue. Two instances share the clock:
//   instance 0 is age-gated (AGE_LIMIT=100) and drops on overflow, instance 1
//   issues immediately and stalls on overflow. Both use DEPTH=4. Expected
//   requests are queued when driven and compared against every observed pop.

module tb_mem_request_queue;

  localparam int TW = 64;
  localparam int AW = 33;
  localparam int OW = 2;
  localparam int CW = 3;

  typedef struct packed {
    logic [TW-1:0] t;
    logic [OW-1:0] op;
    logic [AW-1:0] addr;
  } req_t;

  logic          CPU_clock = 1'b0;
  logic          rst_n       [2];
  logic          in_valid    [2];
  logic [TW-1:0] in_time     [2];
  logic [OW-1:0] in_op       [2];
  logic [AW-1:0] in_addr     [2];
  logic          in_ready    [2];
  logic          out_valid   [2];
  logic          out_ready   [2];
  logic [TW-1:0] out_time    [2];
  logic [OW-1:0] out_op      [2];
  logic [AW-1:0] out_addr    [2];
  logic [TW-1:0] cpu_time    [2];
  logic [CW-1:0] count       [2];
  logic          full        [2];
  logic          empty       [2];
  logic          insert_flag [2];
  logic          exit_flag   [2];
  logic          drop_flag   [2];
  logic [31:0]   drop_count  [2];

  req_t sb_q0 [$];
  req_t sb_q1 [$];
  int   checks = 0;
  int   errors = 0;
  int   pop_count [2];

  always #5 CPU_clock = ~CPU_clock;

  mem_request_queue #(
    .DEPTH(4), .ADDR_W(AW), .OP_W(OW), .TIME_W(TW),
    .AGE_LIMIT(100), .ISSUE_MODE(0), .DROP_ON_FULL(1)
  ) dut_aged (
    .CPU_clock(CPU_clock), .rst_n(rst_n[0]),
    .in_valid(in_valid[0]), .in_time(in_time[0]), .in_op(in_op[0]), .in_addr(in_addr[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_time(out_time[0]), .out_op(out_op[0]), .out_addr(out_addr[0]),
    .cpu_time(cpu_time[0]), .count(count[0]), .full(full[0]), .empty(empty[0]),
    .insert_flag(insert_flag[0]), .exit_flag(exit_flag[0]), .drop_flag(drop_flag[0]),
    .drop_count(drop_count[0])
  );

  mem_request_queue #(
    .DEPTH(4), .ADDR_W(AW), .OP_W(OW), .TIME_W(TW),
    .AGE_LIMIT(100), .ISSUE_MODE(1), .DROP_ON_FULL(0)
  ) dut_fast (
    .CPU_clock(CPU_clock), .rst_n(rst_n[1]),
    .in_valid(in_valid[1]), .in_time(in_time[1]), .in_op(in_op[1]), .in_addr(in_addr[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_time(out_time[1]), .out_op(out_op[1]), .out_addr(out_addr[1]),
    .cpu_time(cpu_time[1]), .count(count[1]), .full(full[1]), .empty(empty[1]),
    .insert_flag(insert_flag[1]), .exit_flag(exit_flag[1]), .drop_flag(drop_flag[1]),
    .drop_count(drop_count[1])
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CPU_clock);
    #1;
  endtask

  task automatic sbPush(input int d, input req_t r);
    if (d == 0) sb_q0.push_back(r);
    else        sb_q1.push_back(r);
  endtask

  task automatic scoreboardCheck(input int d);
    req_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    if (d == 0 && sb_q0.size() > 0) begin
      e = sb_q0.pop_front();
      have = 1'b1;
    end else if (d == 1 && sb_q1.size() > 0) begin
      e = sb_q1.pop_front();
      have = 1'b1;
    end
    if (!have) begin
      checkOutput("sb_unexpected_pop", 64'(out_addr[d]), 64'h0);
      checkOutput("sb_unexpected_pop_flag", 64'd1, 64'd0);
    end else begin
      checkOutput("sb_addr", 64'(out_addr[d]), 64'(e.addr));
      checkOutput("sb_op",   64'(out_op[d]),   64'(e.op));
      checkOutput("sb_time", out_time[d],      e.t);
    end
  endtask

  // Drive one request and hold it until the queue consumes it (bounded wait).
  task automatic applyStimulus(input int d, input logic [TW-1:0] t, input logic [OW-1:0] op,
                               input logic [AW-1:0] addr, input bit keep);
    bit done;
    done = 1'b0;
    in_valid[d] = 1'b1;
    in_time[d]  = t;
    in_op[d]    = op;
    in_addr[d]  = addr;
    if (keep) sbPush(d, req_t'{t, op, addr});
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      if (in_ready[d]) done = 1'b1;
      step();
    end
    in_valid[d] = 1'b0;
    if (!done) checkOutput("in_ready_timeout", 64'd0, 64'd1);
  endtask

  // Pop monitor: sampled mid-cycle, a valid&ready here is a pop at the next edge.
  always @(negedge CPU_clock) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] && out_valid[d] && out_ready[d]) begin
        pop_count[d]++;
        scoreboardCheck(d);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first;
    int base;
    bit seen;

    for (int d = 0; d < 2; d++) begin
      rst_n[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      in_time[d]   = '0;
      in_op[d]     = '0;
      in_addr[d]   = '0;
      out_ready[d] = 1'b0;
      pop_count[d] = 0;
    end

    // T1: reset state
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      checkOutput("t1_empty",      64'(empty[d]),      64'd1);
      checkOutput("t1_full",       64'(full[d]),       64'd0);
      checkOutput("t1_count",      64'(count[d]),      64'd0);
      checkOutput("t1_cpu_time",   cpu_time[d],        64'd0);
      checkOutput("t1_out_valid",  64'(out_valid[d]),  64'd0);
      checkOutput("t1_drop_count", 64'(drop_count[d]), 64'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // T2: time skip on the immediate-issue instance
    step();
    step();
    step();
    checkOutput("t2_cpu_before", cpu_time[1], 64'd3);
    in_valid[1] = 1'b1;
    in_time[1]  = 64'd50;
    in_op[1]    = 2'd1;
    in_addr[1]  = 33'h123;
    sbPush(1, req_t'{64'd50, 2'd1, 33'h123});
    #1;
    checkOutput("t2_not_ready", 64'(in_ready[1]), 64'd0);
    step();
    checkOutput("t2_cpu_skip", cpu_time[1], 64'd50);
    checkOutput("t2_ready",    64'(in_ready[1]), 64'd1);
    step();
    in_valid[1] = 1'b0;
    checkOutput("t2_insert_flag", 64'(insert_flag[1]), 64'd1);
    checkOutput("t2_count",       64'(count[1]),       64'd1);
    checkOutput("t2_out_valid",   64'(out_valid[1]),   64'd1);
    out_ready[1] = 1'b1;
    step();
    out_ready[1] = 1'b0;
    checkOutput("t2_exit_flag", 64'(exit_flag[1]), 64'd1);
    checkOutput("t2_empty",     64'(empty[1]),     64'd1);

    // T3: age-gated latency
    out_ready[0] = 1'b1;
    applyStimulus(0, 64'd0, 2'd0, 33'h0AA, 1'b1);
    checkOutput("t3_insert_flag", 64'(insert_flag[0]), 64'd1);
    checkOutput("t3_not_yet",     64'(out_valid[0]),   64'd0);
    first = -1;
    for (int k = 1; k <= 150 && first < 0; k++) begin
      step();
      if (out_valid[0]) first = k;
    end
    checkOutput("t3_issue_latency", 64'(first), 64'd100);
    step();
    checkOutput("t3_exit_flag", 64'(exit_flag[0]), 64'd1);
    checkOutput("t3_empty",     64'(empty[0]),     64'd1);
    out_ready[0] = 1'b0;

    // T4a: overflow with drop; the fifth request is discarded
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 64'd0, 2'(i % 3), 33'h40 + 33'(i), (i < 4));
    end
    checkOutput("t4_full",       64'(full[0]),       64'd1);
    checkOutput("t4_count",      64'(count[0]),      64'd4);
    checkOutput("t4_drop_count", 64'(drop_count[0]), 64'd1);
    checkOutput("t4_drop_flag",  64'(drop_flag[0]),  64'd1);
    step();
    checkOutput("t4_drop_flag_pulse", 64'(drop_flag[0]), 64'd0);
    out_ready[0] = 1'b1;
    for (int k = 0; k < 300 && sb_q0.size() > 0; k++) step();
    step();
    checkOutput("t4_drain_empty", 64'(empty[0]),    64'd1);
    checkOutput("t4_drain_sb",    64'(sb_q0.size()), 64'd0);
    checkOutput("t4_pops",        64'(pop_count[0]), 64'd5);
    out_ready[0] = 1'b0;

    // T4b: overflow with stall; a same-cycle pop must not admit the held request
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 64'd0, 2'd2, 33'h50 + 33'(i), 1'b1);
    end
    checkOutput("t4s_full",  64'(full[1]),  64'd1);
    checkOutput("t4s_count", 64'(count[1]), 64'd4);
    in_valid[1] = 1'b1;
    in_time[1]  = 64'd0;
    in_op[1]    = 2'd0;
    in_addr[1]  = 33'h54;
    sbPush(1, req_t'{64'd0, 2'd0, 33'h54});
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("t4s_stall_ready", 64'(in_ready[1]), 64'd0);
      step();
    end
    checkOutput("t4s_stall_count", 64'(count[1]), 64'd4);
    out_ready[1] = 1'b1;
    #1;
    checkOutput("t4s_full_pop_no_push", 64'(in_ready[1]), 64'd0);
    step();
    #1;
    checkOutput("t4s_ready_after_pop", 64'(in_ready[1]), 64'd1);
    step();
    in_valid[1] = 1'b0;
    checkOutput("t4s_push_pop_count", 64'(count[1]), 64'd3);
    for (int k = 0; k < 50 && !empty[1]; k++) step();
    checkOutput("t4s_drain_empty", 64'(empty[1]),     64'd1);
    checkOutput("t4s_drain_sb",    64'(sb_q1.size()), 64'd0);

    // T5: wrap and order with back-to-back traffic
    base = pop_count[1];
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 64'd0, 2'(i % 3), 33'(i), 1'b1);
      checkOutput("t5_count_le2", 64'(count[1] <= 3'd2), 64'd1);
    end
    for (int k = 0; k < 50 && !empty[1]; k++) step();
    checkOutput("t5_pops",  64'(pop_count[1] - base), 64'd10);
    checkOutput("t5_sb",    64'(sb_q1.size()),        64'd0);
    checkOutput("t5_empty", 64'(empty[1]),            64'd1);
    out_ready[1] = 1'b0;

    // T6: reset with entries queued; none of them may ever issue
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 64'd0, 2'd1, 33'h1_0000_00A0 + 33'(i), 1'b1);
    end
    checkOutput("t6_count_before", 64'(count[1]), 64'd3);
    rst_n[1] = 1'b0;
    sb_q1.delete();
    step();
    rst_n[1] = 1'b1;
    checkOutput("t6_count",     64'(count[1]),     64'd0);
    checkOutput("t6_out_valid", 64'(out_valid[1]), 64'd0);
    checkOutput("t6_empty",     64'(empty[1]),     64'd1);
    checkOutput("t6_cpu_time",  cpu_time[1],       64'd0);
    out_ready[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (exit_flag[1] || out_valid[1]) seen = 1'b1;
    end
    checkOutput("t6_no_issue", 64'(seen), 64'd0);
    out_ready[1] = 1'b0;

    checkOutput("final_sb0", 64'(sb_q0.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
